// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b, LSB first.
// One full-subtractor cell plus a registered borrow processes one bit per clock.
// An operation takes WIDTH+2 clocks: accept, WIDTH bit-steps, and one DONE cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a new subtraction (only honoured in IDLE)
//   a, b       minuend / subtrahend, captured on the accepting edge
//   busy       high while bits are being processed
//   done       one-cycle pulse when diff/borrow_out have just been updated
//   diff       (a - b) mod 2^WIDTH, held until the next completion
//   borrow_out final unsigned borrow (a < b), held like diff
//
// WIDTH is legal from 2 to 32.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  sd_q, sd_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;

  // Full-subtractor cell on the current LSBs.
  logic             x, y, d_bit, br_step, last_step;
  logic [WIDTH-1:0] sd_shift;

  always_comb begin
    x         = sa_q[0];
    y         = sb_q[0];
    d_bit     = x ^ y ^ br_q;
    br_step   = (~x & y) | (~(x ^ y) & br_q);
    // Result bits enter at the MSB so that after WIDTH steps bit 0 sits at the LSB.
    sd_shift  = {d_bit, sd_q[WIDTH-1:1]};
    last_step = (cnt_q == CntW'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          sd_d    = '0;
        end
      end
      StRun: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sd_d  = sd_shift;
        br_d  = br_step;
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          // Capture from the combinational step so this edge's bit is included.
          diff_d   = sd_shift;
          borrow_d = br_step;
          state_d  = StDone;
        end
      end
      StDone: begin
        // start is deliberately ignored here; it is not queued.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Pure state decodes: no combinational path from inputs.
  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule
